des_key_schedule: RTL and testbench

- Sequential DES round-key generator: accepts a 64-bit key, applies PC-1, then emits round subkeys one per accepted handshake.
- Each subkey is derived through per-round C/D rotations and PC-2.
- Supports encrypt order (K1→K16) and decrypt order (K16→K1) with a parametrised shift schedule.
- Sits between key input and the round datapath, replacing the fixed combinational PC-2 stage as the key-side front end.

---
 rtl/des_key_schedule.sv | 172 +++++++++++++++++
 tb/tb_des_key_schedule.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/des_key_schedule.sv
// Sequential DES round-key generator: PC-1 load, per-round C/D rotation, PC-2 subkey output.
// Optional odd-parity key checking (adds parity_err) when DES_KS_PARITY_CHECK_EN is defined.
module des_key_schedule #(
    parameter logic [15:0] SHIFT_SCHEDULE = 16'h7EFC
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [63:0] key,
    input  logic        decrypt,
    output logic        ready,
    output logic        subkey_valid,
    input  logic        subkey_ready,
    output logic [47:0] subkey,
    output logic [3:0]  subkey_round,
    output logic        done
`ifdef DES_KS_PARITY_CHECK_EN
    ,
    output logic        parity_err
`endif
);

    typedef enum logic {IDLE, EMIT} state_t;

    // Table entries are 1-based DES bit numbers
    localparam logic [5:0] PC1_T [56] = '{
        6'd57, 6'd49, 6'd41, 6'd33, 6'd25, 6'd17, 6'd9,
        6'd1,  6'd58, 6'd50, 6'd42, 6'd34, 6'd26, 6'd18,
        6'd10, 6'd2,  6'd59, 6'd51, 6'd43, 6'd35, 6'd27,
        6'd19, 6'd11, 6'd3,  6'd60, 6'd52, 6'd44, 6'd36,
        6'd63, 6'd55, 6'd47, 6'd39, 6'd31, 6'd23, 6'd15,
        6'd7,  6'd62, 6'd54, 6'd46, 6'd38, 6'd30, 6'd22,
        6'd14, 6'd6,  6'd61, 6'd53, 6'd45, 6'd37, 6'd29,
        6'd21, 6'd13, 6'd5,  6'd28, 6'd20, 6'd12, 6'd4
    };

    localparam logic [5:0] PC2_T [48] = '{
        6'd14, 6'd17, 6'd11, 6'd24, 6'd1,  6'd5,
        6'd3,  6'd28, 6'd15, 6'd6,  6'd21, 6'd10,
        6'd23, 6'd19, 6'd12, 6'd4,  6'd26, 6'd8,
        6'd16, 6'd7,  6'd27, 6'd20, 6'd13, 6'd2,
        6'd41, 6'd52, 6'd31, 6'd37, 6'd47, 6'd55,
        6'd30, 6'd40, 6'd51, 6'd45, 6'd33, 6'd48,
        6'd44, 6'd49, 6'd39, 6'd56, 6'd34, 6'd53,
        6'd46, 6'd42, 6'd50, 6'd36, 6'd29, 6'd32
    };

    function automatic logic [55:0] pc1(input logic [63:0] k);
        logic [55:0] p;
        for (int unsigned j = 0; j < 56; j++) p[j] = k[PC1_T[j] - 6'd1];
        return p;
    endfunction

    // DES rotate-left: out[i] = x[(i+n) mod 28]
    function automatic logic [27:0] rotl(input logic [27:0] x, input logic two);
        return two ? {x[1:0], x[27:2]} : {x[0], x[27:1]};
    endfunction

    function automatic logic [27:0] rotr(input logic [27:0] x, input logic two);
        return two ? {x[25:0], x[27:26]} : {x[26:0], x[27]};
    endfunction

    state_t      state, state_nxt;
    logic [27:0] c_reg, c_nxt, d_reg, d_nxt;
    logic [3:0]  cnt, cnt_nxt;
    logic        dec_reg, dec_nxt;
    logic        done_nxt;
    logic [55:0] key_pc1;
    logic [55:0] cd;
    logic        key_ok;

`ifdef DES_KS_PARITY_CHECK_EN
    logic perr_nxt;
    assign key_ok = &{^key[63:56], ^key[55:48], ^key[47:40], ^key[39:32],
                      ^key[31:24], ^key[23:16], ^key[15:8],  ^key[7:0]};
`else
    logic unused_parity_bits;
    assign unused_parity_bits = ^{key[63], key[55], key[47], key[39],
                                  key[31], key[23], key[15], key[7]};
    assign key_ok = 1'b1;
`endif

    always_comb begin
        state_nxt = state;
        c_nxt     = c_reg;
        d_nxt     = d_reg;
        cnt_nxt   = cnt;
        dec_nxt   = dec_reg;
        done_nxt  = 1'b0;
`ifdef DES_KS_PARITY_CHECK_EN
        perr_nxt  = 1'b0;
`endif
        key_pc1   = pc1(key);
        case (state)
            IDLE: begin
                if (start) begin
                    if (key_ok) begin
                        state_nxt = EMIT;
                        dec_nxt   = decrypt;
                        cnt_nxt   = '0;
                        // Decrypt starts from C0/D0, which equals C16/D16 after a full 28-bit turn
                        if (decrypt) begin
                            c_nxt = key_pc1[27:0];
                            d_nxt = key_pc1[55:28];
                        end else begin
                            c_nxt = rotl(key_pc1[27:0], SHIFT_SCHEDULE[0]);
                            d_nxt = rotl(key_pc1[55:28], SHIFT_SCHEDULE[0]);
                        end
                    end
`ifdef DES_KS_PARITY_CHECK_EN
                    else begin
                        perr_nxt = 1'b1;
                    end
`endif
                end
            end
            EMIT: begin
                if (subkey_ready) begin
                    if (cnt == 4'd15) begin
                        state_nxt = IDLE;
                        done_nxt  = 1'b1;
                    end else begin
                        cnt_nxt = cnt + 4'd1;
                        if (dec_reg) begin
                            c_nxt = rotr(c_reg, SHIFT_SCHEDULE[4'd15 - cnt]);
                            d_nxt = rotr(d_reg, SHIFT_SCHEDULE[4'd15 - cnt]);
                        end else begin
                            c_nxt = rotl(c_reg, SHIFT_SCHEDULE[cnt + 4'd1]);
                            d_nxt = rotl(d_reg, SHIFT_SCHEDULE[cnt + 4'd1]);
                        end
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            c_reg   <= '0;
            d_reg   <= '0;
            cnt     <= '0;
            dec_reg <= 1'b0;
            done    <= 1'b0;
`ifdef DES_KS_PARITY_CHECK_EN
            parity_err <= 1'b0;
`endif
        end else begin
            state   <= state_nxt;
            c_reg   <= c_nxt;
            d_reg   <= d_nxt;
            cnt     <= cnt_nxt;
            dec_reg <= dec_nxt;
            done    <= done_nxt;
`ifdef DES_KS_PARITY_CHECK_EN
            parity_err <= perr_nxt;
`endif
        end
    end

    assign ready        = (state == IDLE);
    assign subkey_valid = (state == EMIT);
    assign subkey_round = dec_reg ? (4'd15 - cnt) : cnt;
    assign cd           = {d_reg, c_reg};

    always_comb begin
        subkey = '0;
        for (int unsigned j = 0; j < 48; j++) subkey[j] = cd[PC2_T[j] - 6'd1];
    end

endmodule

// File: tb/tb_des_key_schedule.sv
// Self-checking bench for des_key_schedule: closed-form DES key-schedule model plus literal vectors.
module tb_des_key_schedule;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [63:0] key = '0;
    logic        decrypt = 1'b0;
    logic        subkey_ready = 1'b0;
    logic        ready, subkey_valid, done;
    logic [47:0] subkey;
    logic [3:0]  subkey_round;
`ifdef DES_KS_PARITY_CHECK_EN
    logic        parity_err;
`endif

    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    des_key_schedule #(.SHIFT_SCHEDULE(16'h7EFC)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .key          (key),
        .decrypt      (decrypt),
        .ready        (ready),
        .subkey_valid (subkey_valid),
        .subkey_ready (subkey_ready),
        .subkey       (subkey),
        .subkey_round (subkey_round),
        .done         (done)
`ifdef DES_KS_PARITY_CHECK_EN
        ,
        .parity_err   (parity_err)
`endif
    );

    int PC1 [56] = '{57,49,41,33,25,17,9, 1,58,50,42,34,26,18, 10,2,59,51,43,35,27,
                     19,11,3,60,52,44,36, 63,55,47,39,31,23,15, 7,62,54,46,38,30,22,
                     14,6,61,53,45,37,29, 21,13,5,28,20,12,4};
    int PC2 [48] = '{14,17,11,24,1,5, 3,28,15,6,21,10, 23,19,12,4,26,8, 16,7,27,20,13,2,
                     41,52,31,37,47,55, 30,40,51,45,33,48, 44,49,39,56,34,53, 46,42,50,36,29,32};
    int SHIFTS [16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: timed out waiting, expected event within bound at %0t", name, $time);
    endtask

    function automatic logic [63:0] rev64(input logic [63:0] x);
        logic [63:0] r;
        for (int i = 0; i < 64; i++) r[i] = x[63-i];
        return r;
    endfunction

    function automatic logic [47:0] rev48(input logic [47:0] x);
        logic [47:0] r;
        for (int i = 0; i < 48; i++) r[i] = x[47-i];
        return r;
    endfunction

    // Subkey for DES round r (1..16) from the cumulative rotation amount
    function automatic logic [47:0] model_key(input logic [63:0] k, input int r);
        logic [27:0] c0, d0;
        logic [47:0] o;
        int s, p;
        for (int j = 0; j < 28; j++) begin
            c0[j] = k[PC1[j]-1];
            d0[j] = k[PC1[j+28]-1];
        end
        s = 0;
        for (int i = 0; i < r; i++) s += SHIFTS[i];
        for (int j = 0; j < 48; j++) begin
            p = PC2[j] - 1;
            o[j] = (p < 28) ? c0[(p + s) % 28] : d0[(p - 28 + s) % 28];
        end
        return o;
    endfunction

    function automatic bit parity_ok(input logic [63:0] k);
        bit ok = 1'b1;
`ifdef DES_KS_PARITY_CHECK_EN
        for (int b = 0; b < 8; b++) if (^k[8*b +: 8] == 1'b0) ok = 1'b0;
`endif
        return ok;
    endfunction

    function automatic logic [63:0] rand_key();
        logic [63:0] k = {$urandom, $urandom};
`ifdef DES_KS_PARITY_CHECK_EN
        for (int b = 0; b < 8; b++) k[8*b+7] = ~^k[8*b +: 7];
`endif
        return k;
    endfunction

    // Behavioural model and compare process, evaluated mid-cycle
    bit          m_active = 1'b0;
    bit          m_dec = 1'b0;
    bit          m_done = 1'b0;
    bit          m_perr = 1'b0;
    int          m_idx = 0;
    int          m_r;
    logic [47:0] m_keys [16];

    always @(negedge clk) begin
        if (!rst_n) begin
            check("rst_ready", ready, 1);
            check("rst_valid", subkey_valid, 0);
            check("rst_done", done, 0);
            check("rst_subkey", subkey, 0);
            check("rst_round", subkey_round, 0);
`ifdef DES_KS_PARITY_CHECK_EN
            check("rst_parity_err", parity_err, 0);
`endif
            m_active = 1'b0;
            m_done = 1'b0;
            m_perr = 1'b0;
            m_idx = 0;
        end else begin
            check("ready", ready, !m_active);
            check("subkey_valid", subkey_valid, m_active);
            check("done", done, m_done);
`ifdef DES_KS_PARITY_CHECK_EN
            check("parity_err", parity_err, m_perr);
`endif
            if (m_active) begin
                m_r = m_dec ? 15 - m_idx : m_idx;
                check("subkey", subkey, m_keys[m_r]);
                check("subkey_round", subkey_round, m_r);
            end
            m_done = 1'b0;
            m_perr = 1'b0;
            if (m_active) begin
                if (subkey_ready) begin
                    if (m_idx == 15) begin
                        m_active = 1'b0;
                        m_done = 1'b1;
                    end else begin
                        m_idx++;
                    end
                end
            end else if (start) begin
                if (parity_ok(key)) begin
                    for (int r = 0; r < 16; r++) m_keys[r] = model_key(key, r + 1);
                    m_dec = decrypt;
                    m_idx = 0;
                    m_active = 1'b1;
                end else begin
                    m_perr = 1'b1;
                end
            end
        end
    end

    task automatic wait_ready(input string name);
        bit got = 1'b0;
        for (int c = 0; c < 100; c++) begin
            if (ready) begin
                got = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        if (!got) timeout_fail(name);
    endtask

    task automatic wait_done(input string name, input bit random_bp, input bit poke_start);
        bit got = 1'b0;
        for (int c = 0; c < 300; c++) begin
            @(posedge clk);
            #1;
            if (random_bp) subkey_ready = ($urandom_range(0, 2) != 0);
            if (poke_start && c == 3) begin
                start = 1'b1;
                key = rand_key();
                decrypt = ~decrypt;
            end else begin
                start = 1'b0;
            end
            if (done) begin
                got = 1'b1;
                break;
            end
        end
        start = 1'b0;
        if (!got) timeout_fail(name);
    endtask

    logic [63:0] KEY;
    logic [47:0] K1, K16;
    logic [63:0] k2;

    initial begin
        KEY = rev64(64'h133457799BBCDFF1);
        K1  = rev48(48'h1B02EFFC7072);
        K16 = rev48(48'hCB3D8B0E17F5);
        check("model_k1", model_key(KEY, 1), K1);
        check("model_k16", model_key(KEY, 16), K16);

        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;

        // Encrypt with the reference key, no backpressure
        @(posedge clk); #1;
        key = KEY; decrypt = 1'b0; start = 1'b1; subkey_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; key = rand_key(); decrypt = 1'b1;
        check("enc_t1_subkey", subkey, K1);
        check("enc_t1_round", subkey_round, 0);
        repeat (15) @(posedge clk);
        #1;
        check("enc_t16_subkey", subkey, K16);
        check("enc_t16_round", subkey_round, 15);
        @(posedge clk); #1;
        check("enc_t17_done", done, 1);
        check("enc_t17_ready", ready, 1);

        // Decrypt, started in the done cycle
        key = KEY; decrypt = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("dec_t1_valid", subkey_valid, 1);
        check("dec_t1_subkey", subkey, K16);
        check("dec_t1_round", subkey_round, 15);
        repeat (15) @(posedge clk);
        #1;
        check("dec_t16_subkey", subkey, K1);
        check("dec_t16_round", subkey_round, 0);
        @(posedge clk); #1;
        check("dec_t17_done", done, 1);

        // Random keys/modes with random backpressure and an ignored start mid-schedule
        for (int n = 0; n < 6; n++) begin
            wait_ready("bp_ready");
            @(posedge clk); #1;
            key = rand_key(); decrypt = 1'($urandom_range(0, 1)); start = 1'b1;
            subkey_ready = 1'($urandom_range(0, 1));
            wait_done("bp_done", 1'b1, 1'b1);
        end

        // Reset mid-schedule after round 5 is accepted
        subkey_ready = 1'b1;
        wait_ready("rst_ready_wait");
        @(posedge clk); #1;
        key = rand_key(); decrypt = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (6) @(posedge clk);
        #2;
        check("pre_reset_round", subkey_round, 6);
        rst_n = 1'b0;
        #1;
        check("async_rst_ready", ready, 1);
        check("async_rst_valid", subkey_valid, 0);
        check("async_rst_subkey", subkey, 0);
        check("async_rst_round", subkey_round, 0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        #1 check("post_rst_ready", ready, 1);
        @(posedge clk); #1;
        k2 = rand_key();
        key = k2; decrypt = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("post_rst_first", subkey, model_key(k2, 16));
        wait_done("post_rst_done", 1'b1, 1'b0);

`ifdef DES_KS_PARITY_CHECK_EN
        // All-zero key has even parity in every byte
        wait_ready("par_ready");
        @(posedge clk); #1;
        key = '0; decrypt = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("par_err_pulse", parity_err, 1);
        check("par_ready", ready, 1);
        check("par_valid", subkey_valid, 0);
        @(posedge clk); #1;
        check("par_err_clear", parity_err, 0);
        check("par_valid2", subkey_valid, 0);
`endif

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, got time %0t", $time);
        $fatal(1, "global timeout");
    end

endmodule
